pipe_hazard_ctrl: RTL

Hazard and stall scheduler for the five-stage pipeline (PC → FI/ID → ID/EX → EX/MEM → MEM/WB). Each cycle it decides which pipeline registers hold, which receive a bubble and which are flushed. The inputs it weighs are load-use dependencies, taken branches, instruction-fetch wait states and multi-cycle data-memory accesses. A small state machine tracks outstanding data-memory waits, enforces a timeout and raises a sticky error.

---
 rtl/pipe_hazard_ctrl.sv | 84 ++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/flush scheduler with data-memory wait FSM; perf counters under PIPE_HAZARD_PERF_EN
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_load,
    input  logic [4:0]       ex_wreg,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_pause,
    output logic             fi_id_pause,
    output logic             fi_id_flush,
    output logic             id_ex_pause,
    output logic             id_ex_bubble,
    output logic             ex_mem_pause,
    output logic             mem_wb_pause,
    output logic             mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_ld_cnt,
    output logic [CNT_W-1:0] stall_mem_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MWAIT, ERR} state_t;

    state_t        state;
    logic [WW-1:0] wcnt, nx;
    logic          waiting, mf, lu;

    // A data access is still outstanding this cycle (an ack releases the freeze immediately)
    assign waiting = (state == RUN) ? (mem_req && !mem_ack) : (state == MWAIT && !mem_ack);
    assign mf      = rst && (state == ERR || waiting);
    assign lu      = rst && ex_load && ex_wreg != 5'd0 &&
                     ((id_use_rs && id_rs == ex_wreg) || (id_use_rt && id_rt == ex_wreg));
    assign nx      = (state == RUN) ? WW'(1) : wcnt + 1'b1;

    assign pc_pause     = mf || lu || (rst && !imem_ready);
    assign fi_id_pause  = mf || lu;
    assign fi_id_flush  = rst && !mf && !lu && (branch_taken || !imem_ready);
    assign id_ex_pause  = mf;
    assign id_ex_bubble = !mf && lu;
    assign ex_mem_pause = mf;
    assign mem_wb_pause = mf;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            wcnt    <= '0;
            mem_err <= 1'b0;
        end else if (waiting) begin
            wcnt    <= nx;
            state   <= (nx == WW'(MEM_TIMEOUT)) ? ERR : MWAIT;
            mem_err <= nx == WW'(MEM_TIMEOUT);
        end else if (state == MWAIT) begin
            state <= RUN;
            wcnt  <= '0;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_ld_cnt  <= '0;
            stall_mem_cnt <= '0;
            flush_cnt     <= '0;
        end else begin
            if (id_ex_bubble && !(&stall_ld_cnt)) stall_ld_cnt <= stall_ld_cnt + 1'b1;
            if (mf && !(&stall_mem_cnt)) stall_mem_cnt <= stall_mem_cnt + 1'b1;
            if (fi_id_flush && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif
endmodule
